// File: rtl/lockin_keys_pkg.sv
// Shared LockIn key constants and 50 MHz debounce defaults.
// Tick-based debounce is selected with the KEY_DEBOUNCE_TICK_EN macro.
package lockin_keys_pkg;

    localparam int   N_KEYS_DEF          = 4;
    localparam int   DEBOUNCE_CYCLES_DEF = 1_000_000;
    localparam int   TICK_DIV_DEF        = 50_000;

    localparam logic KEY_PRESSED  = 1'b0;
    localparam logic KEY_RELEASED = 1'b1;

    function automatic logic is_pressed(input logic k);
        return k == KEY_PRESSED;
    endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// One key: 2-FF synchroniser, stability counter and clean register.
// Counting advances only while cnt_en is high.
module key_debounce_channel
    import lockin_keys_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic cnt_en,
    input  logic key_raw,
    output logic key_clean
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          clean_q, clean_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    always_comb begin
        sync1_d = key_raw;
        sync2_d = sync1_q;
        clean_d = clean_q;
        cnt_d   = cnt_q;
        if (cnt_en) begin
            if (sync2_q == clean_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                // full run of disagreeing samples: accept the new level
                clean_d = sync2_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= KEY_RELEASED;
            sync2_q <= KEY_RELEASED;
            clean_q <= KEY_RELEASED;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            clean_q <= clean_d;
            cnt_q   <= cnt_d;
        end
    end

    assign key_clean = clean_q;

endmodule

// File: rtl/key_debouncer.sv
// Debounces N_KEYS active-low board keys into the clk domain.
// Define KEY_DEBOUNCE_TICK_EN to count in TICK_DIV-cycle prescaler ticks.
module key_debouncer
    import lockin_keys_pkg::*;
#(
    parameter int N_KEYS          = N_KEYS_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int TICK_DIV        = TICK_DIV_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] keys_raw,
    output logic [N_KEYS-1:0] keys_clean
);

    logic cnt_en;

`ifdef KEY_DEBOUNCE_TICK_EN
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic          tick;

    always_comb begin
        tick  = (pre_q == PRE_LAST);
        pre_d = tick ? '0 : pre_q + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    assign cnt_en = tick;
`else
    assign cnt_en = 1'b1;
`endif

    // Illegal parameters leave every key parked at released.
    if (DEBOUNCE_CYCLES >= 1 && TICK_DIV >= 1) begin : g_keys
        for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
            key_debounce_channel #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_ch (
                .clk      (clk),
                .rst      (rst),
                .cnt_en   (cnt_en),
                .key_raw  (keys_raw[i]),
                .key_clean(keys_clean[i])
            );
        end
    end else begin : g_off
        assign keys_clean = {N_KEYS{KEY_RELEASED}};
    end

endmodule

// File: tb/tb_key_debouncer.sv
// Self-checking bench for key_debouncer (DEBOUNCE_CYCLES=8, TICK_DIV=4).
// Builds with KEY_DEBOUNCE_TICK_EN run the tick-window scenarios instead.
module tb_key_debouncer;
    import lockin_keys_pkg::*;

    localparam int NK = 4;
    localparam int D  = 8;
    localparam int TD = 4;
`ifdef KEY_DEBOUNCE_TICK_EN
    localparam bit USE_SB = 1'b0;
    localparam int NROWS  = 8;
`else
    localparam bit USE_SB = 1'b1;
    localparam int NROWS  = 25;
`endif

    typedef struct {
        logic          rst;
        logic [NK-1:0] raw;
        int            cycles;
        logic [NK-1:0] exp_end;
    } seg_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NK-1:0] keys_raw = '1;
    logic [NK-1:0] keys_clean;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    seg_t rows [NROWS];
    int   row_start [NROWS];

    logic [NK-1:0] sb [$];
    logic [NK-1:0] m_s1;
    logic [NK-1:0] m_clean;
    logic [NK-1:0] m_win [D];

    logic [NK-1:0] prev_clean = '1;
    int            chg_e [NK][$];

    key_debouncer #(
        .N_KEYS         (NK),
        .DEBOUNCE_CYCLES(D),
        .TICK_DIV       (TD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .keys_raw  (keys_raw),
        .keys_clean(keys_clean)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: a window of the last D synchronised samples; the clean
    // level flips once all D disagree with it.
    task automatic model_edge(input logic r, input logic [NK-1:0] raw);
        logic [NK-1:0] flip;
        if (r) begin
            m_s1    = '1;
            m_clean = '1;
            for (int i = 0; i < D; i++) m_win[i] = '1;
        end else begin
            flip = '1;
            for (int i = 0; i < D; i++) flip &= m_win[i] ^ m_clean;
            m_clean = m_clean ^ flip;
            for (int i = D - 1; i > 0; i--) m_win[i] = m_win[i-1];
            m_win[0] = m_s1;
            m_s1     = raw;
        end
    endtask

    task automatic step(input logic r, input logic [NK-1:0] raw);
        rst      = r;
        keys_raw = raw;
        @(posedge clk);
        edge_n++;
        #1;
        model_edge(r, raw);
        if (USE_SB) sb.push_back(m_clean);
    endtask

    always @(negedge clk) begin
        logic [NK-1:0] e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (keys_clean !== e) begin
                errors++;
                $display("FAIL sb edge %0d: keys_clean %b expected %b",
                         edge_n, keys_clean, e);
            end
        end
        for (int b = 0; b < NK; b++) begin
            if (keys_clean[b] != prev_clean[b]) chg_e[b].push_back(edge_n);
        end
        prev_clean = keys_clean;
    end

    function automatic int first_chg(input int b, input int lo, input int hi);
        foreach (chg_e[b][i]) begin
            if (chg_e[b][i] >= lo && chg_e[b][i] <= hi) return chg_e[b][i];
        end
        return -1;
    endfunction

    function automatic int n_chg(input int b, input int lo, input int hi);
        int n = 0;
        foreach (chg_e[b][i]) begin
            if (chg_e[b][i] >= lo && chg_e[b][i] <= hi) n++;
        end
        return n;
    endfunction

    function automatic seg_t mk(input logic r, input logic [NK-1:0] raw,
                                input int cyc, input logic [NK-1:0] ex);
        seg_t s;
        s.rst = r; s.raw = raw; s.cycles = cyc; s.exp_end = ex;
        return s;
    endfunction

    initial begin
        int e;
        int lat;
`ifdef KEY_DEBOUNCE_TICK_EN
        rows[0] = mk(1'b1, 4'b1111,  3, 4'b1111);
        rows[1] = mk(1'b0, 4'b1111, 10, 4'b1111);
        rows[2] = mk(1'b0, 4'b0111, 40, 4'b0111);
        rows[3] = mk(1'b0, 4'b1111, 40, 4'b1111);
        rows[4] = mk(1'b0, 4'b0111,  5, 4'b1111);
        rows[5] = mk(1'b1, 4'b0111,  2, 4'b1111);
        rows[6] = mk(1'b0, 4'b0111, 40, 4'b0111);
        rows[7] = mk(1'b0, 4'b1111, 40, 4'b1111);
`else
        rows[0] = mk(1'b1, 4'b0000,  3, 4'b1111);
        rows[1] = mk(1'b0, 4'b0000, 12, 4'b0000);
        rows[2] = mk(1'b0, 4'b1111, 12, 4'b1111);
        rows[3] = mk(1'b0, 4'b1110, 20, 4'b1110);
        rows[4] = mk(1'b0, 4'b1111, 12, 4'b1111);
        for (int i = 0; i < 10; i++)
            rows[5+i] = mk(1'b0, (i % 2 == 0) ? 4'b1101 : 4'b1111, 3, 4'b1111);
        rows[15] = mk(1'b0, 4'b1101, 12, 4'b1101);
        rows[16] = mk(1'b0, 4'b1111, 12, 4'b1111);
        rows[17] = mk(1'b0, 4'b1011,  7, 4'b1111);
        rows[18] = mk(1'b0, 4'b1111, 12, 4'b1111);
        rows[19] = mk(1'b0, 4'b0000, 20, 4'b0000);
        rows[20] = mk(1'b0, 4'b1111, 12, 4'b1111);
        rows[21] = mk(1'b0, 4'b0111,  5, 4'b1111);
        rows[22] = mk(1'b1, 4'b0111,  2, 4'b1111);
        rows[23] = mk(1'b0, 4'b0111, 12, 4'b0111);
        rows[24] = mk(1'b0, 4'b1111, 12, 4'b1111);
`endif

        for (int r = 0; r < NROWS; r++) begin
            row_start[r] = edge_n + 1;
            for (int c = 0; c < rows[r].cycles; c++)
                step(rows[r].rst, rows[r].raw);
            chk($sformatf("row%0d_end", r), int'(keys_clean),
                int'(rows[r].exp_end));
        end
        @(negedge clk);

`ifdef KEY_DEBOUNCE_TICK_EN
        foreach (row_start[r]) begin
            if (r == 2 || r == 3 || r == 6) begin
                e   = first_chg(3, row_start[r], row_start[r] + 39);
                lat = e - row_start[r] + 1;
                chk($sformatf("tick_win_lo_row%0d", r), int'(lat >= 30), 1);
                chk($sformatf("tick_win_hi_row%0d", r), int'(lat <= 34), 1);
            end
        end
        chk("tick_midrst_hold", n_chg(3, row_start[4], row_start[6] - 1), 0);
`else
        for (int b = 0; b < NK; b++) begin
            chk($sformatf("rst_hold_b%0d", b),
                n_chg(b, row_start[0], row_start[1] + 8), 0);
            chk($sformatf("rst_fall_b%0d", b),
                first_chg(b, row_start[1], row_start[1] + 11), row_start[1] + 9);
            chk($sformatf("sim_fall_b%0d", b),
                first_chg(b, row_start[19], row_start[19] + 19), row_start[19] + 9);
            chk($sformatf("sim_rise_b%0d", b),
                first_chg(b, row_start[20], row_start[20] + 11), row_start[20] + 9);
        end
        chk("press_fall_b0",
            first_chg(0, row_start[3], row_start[3] + 19), row_start[3] + 9);
        chk("press_rise_b0",
            first_chg(0, row_start[4], row_start[4] + 11), row_start[4] + 9);
        for (int b = 1; b < NK; b++)
            chk($sformatf("press_quiet_b%0d", b),
                n_chg(b, row_start[3], row_start[4] + 11), 0);
        chk("bounce_one_fall", n_chg(1, row_start[5], row_start[15] + 11), 1);
        chk("bounce_fall_edge",
            first_chg(1, row_start[5], row_start[15] + 11), row_start[15] + 9);
        chk("glitch_quiet_b2", n_chg(2, row_start[17], row_start[18] + 11), 0);
        chk("midrst_one_fall", n_chg(3, row_start[21], row_start[23] + 11), 1);
        chk("midrst_fall_edge",
            first_chg(3, row_start[21], row_start[23] + 11), row_start[23] + 9);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
